// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a small
// prefetch FIFO whose head drives decode. Redirect flushes and restarts fetch.
module fetch_prefetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [INSTR_W-1:0] NOP      = 16'h0800,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_done,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               mem_err,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               halt,
    output logic               err
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] WRAP_PC = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, REQ, HALTED} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               discard;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     occ;
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic               push;
    logic               pop;

    assign push = (state == REQ) && mem_done && !redirect;
    assign pop  = instr_valid && !stall && !redirect;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            err      <= 1'b0;
        end else if (redirect) begin
            state    <= IDLE;
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            // An abandoned request still owes us a response; swallow it later.
            discard  <= (state == REQ || discard) && !mem_done;
        end else begin
            if (discard && mem_done)
                discard <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            case (state)
                IDLE: if (!discard && occ != FULL) state <= REQ;
                REQ: if (mem_done) begin
                    fetch_pc <= fetch_pc + STEP;
                    if (mem_err || fetch_pc == WRAP_PC)
                        err <= 1'b1;
                    state <= (mem_data == '0) ? HALTED : IDLE;
                end
                default: ;
            endcase
        end
    end

    assign instr_valid = (occ != '0);
    assign instr       = instr_valid ? q_instr[rd_ptr] : NOP;
    assign pc          = instr_valid ? q_pc[rd_ptr] : '0;
    assign pc_next     = pc + STEP;
    assign halt        = instr_valid && (q_instr[rd_ptr] == '0);
    assign mem_req     = (state == REQ);
    assign mem_addr    = fetch_pc;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a latency-programmable memory model.
module tb_fetch_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [15:0] mem_data = '0;
    logic        mem_err = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        halt;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [0:65535];
    int          lat = 1;
    logic        inj_err = 1'b0;
    logic        pending = 1'b0;
    logic [15:0] paddr = '0;
    int          cnt = 0;
    int          done_cnt = 0;

    fetch_prefetch dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data), .mem_err(mem_err),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_next(pc_next),
        .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    // Memory: latches a request, answers with a one-cycle done after lat cycles,
    // even if the request was withdrawn meanwhile.
    always @(posedge clk) begin
        #1;
        mem_done = 1'b0;
        mem_err  = 1'b0;
        if (!rst) begin
            pending = 1'b0;
        end else if (pending) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                mem_done = 1'b1;
                mem_data = mem[paddr];
                mem_err  = inj_err;
                pending  = 1'b0;
                done_cnt = done_cnt + 1;
            end
        end else if (mem_req) begin
            pending = 1'b1;
            paddr   = mem_addr;
            cnt     = lat;
        end
    end

    task automatic do_reset();
        rst = 1'b0; redirect = 1'b0; stall = 1'b0; inj_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 16'h0800) begin failures++; $display("FAIL rst_instr got=%h exp=0800", instr); end
        checks++; if (halt !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_halt_err got=%b%b exp=00", halt, err); end
        checks++; if (pc !== 16'h0000 || pc_next !== 16'h0002) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0000/0002", pc, pc_next); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0000", mem_req, mem_addr); end
    endtask

    task automatic test_basic();
        int n;
        lat = 1; do_reset(); stall = 1'b1;
        n = 0;
        while (!mem_done && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL basic_done_timeout got=%0d exp<20", n); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", instr_valid); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || pc !== 16'h0000 || instr !== 16'h1111 || pc_next !== 16'h0002)
            begin failures++; $display("FAIL basic_head0 got=%b/%h/%h/%h exp=1/0000/1111/0002", instr_valid, pc, instr, pc_next); end
        repeat (6) @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        checks++; if (instr_valid !== 1'b1 || pc !== 16'h0002 || instr !== 16'h2222 || pc_next !== 16'h0004)
            begin failures++; $display("FAIL basic_head1 got=%b/%h/%h/%h exp=1/0002/2222/0004", instr_valid, pc, instr, pc_next); end
    endtask

    task automatic test_stall();
        int d0;
        lat = 1; do_reset(); stall = 1'b1;
        d0 = done_cnt;
        repeat (16) @(negedge clk);
        checks++; if (done_cnt - d0 != 4) begin failures++; $display("FAIL stall_pushes got=%0d exp=4", done_cnt - d0); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_full_req got=%b exp=0", mem_req); end
        checks++; if (pc !== 16'h0000 || instr !== 16'h1111) begin failures++; $display("FAIL stall_head got=%h/%h exp=0000/1111", pc, instr); end
        stall = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1 || pc !== 16'(2*k) || instr !== mem[2*k])
                begin failures++; $display("FAIL stall_drain%0d got=%b/%h/%h exp=1/%h/%h", k, instr_valid, pc, instr, 16'(2*k), mem[2*k]); end
        end
    endtask

    task automatic test_redirect();
        int n;
        int d0;
        logic seen_valid;
        lat = 3; do_reset(); stall = 1'b1;
        n = 0;
        while (!(mem_req && mem_addr == 16'h0006) && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin failures++; $display("FAIL redir_wait6 got=%0d exp<100", n); end
        d0 = done_cnt;
        redirect = 1'b1; redirect_pc = 16'h0100; inj_err = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b/%b exp=0/0", instr_valid, mem_req); end
        n = 0; seen_valid = 1'b0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; seen_valid |= instr_valid; end
        inj_err = 1'b0;
        checks++; if (n >= 20 || mem_addr !== 16'h0100) begin failures++; $display("FAIL redir_addr got=%h exp=0100", mem_addr); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL redir_late_first got=%0d exp=1", done_cnt - d0); end
        checks++; if (seen_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL redir_dropped got=%b/%b exp=0/0", seen_valid, err); end
        n = 0;
        while (!instr_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (pc !== 16'h0100 || instr !== 16'hA100) begin failures++; $display("FAIL redir_head got=%h/%h exp=0100/a100", pc, instr); end
    endtask

    task automatic test_redirect_done();
        int n;
        lat = 1; do_reset(); stall = 1'b1;
        n = 0;
        while (!mem_done && n < 20) begin @(negedge clk); n++; end
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rd_same_drop got=%b/%b exp=0/0", instr_valid, mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin failures++; $display("FAIL rd_same_restart got=%b/%h exp=1/0200", mem_req, mem_addr); end
    endtask

    task automatic test_halt();
        int n;
        logic req_seen;
        mem[8] = 16'h0000;
        lat = 1; do_reset(); stall = 1'b0;
        n = 0;
        while (!halt && n < 60) begin @(negedge clk); n++; end
        stall = 1'b1;
        checks++; if (n >= 60 || pc !== 16'h0008 || instr !== 16'h0000) begin failures++; $display("FAIL halt_head got=%h/%h exp=0008/0000", pc, instr); end
        req_seen = 1'b0;
        repeat (5) begin @(negedge clk); req_seen |= mem_req; end
        checks++; if (req_seen !== 1'b0 || halt !== 1'b1) begin failures++; $display("FAIL halt_hold got=%b/%b exp=0/1", req_seen, halt); end
        redirect = 1'b1; redirect_pc = 16'h0000;
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0;
        checks++; if (instr_valid !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL halt_flush got=%b/%b exp=0/0", instr_valid, halt); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL halt_resume got=%b/%h exp=1/0000", mem_req, mem_addr); end
        mem[8] = 16'hA008;
    endtask

    task automatic test_wrap();
        int n;
        lat = 1; do_reset(); stall = 1'b1;
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        @(negedge clk);
        redirect = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 16'hFFFE) && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20 || err !== 1'b0) begin failures++; $display("FAIL wrap_pre got=%0d/%b exp<20/0", n, err); end
        n = 0;
        while (!(mem_req && mem_addr == 16'h0000) && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20 || err !== 1'b1) begin failures++; $display("FAIL wrap_err got=%0d/%b exp<20/1", n, err); end
        inj_err = 1'b1;
        n = 0;
        while (!mem_done && n < 20) begin @(negedge clk); n++; end
        inj_err = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL wrap_err_sticky got=%b exp=1", err); end
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        checks++; if (pc !== 16'hFFFE || pc_next !== 16'h0000) begin failures++; $display("FAIL wrap_pc_next got=%h/%h exp=fffe/0000", pc, pc_next); end
    endtask

    task automatic test_mem_err();
        int n;
        lat = 1; do_reset(); stall = 1'b1; inj_err = 1'b1;
        n = 0;
        while (!mem_done && n < 20) begin @(negedge clk); n++; end
        inj_err = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL memerr_pre got=%b exp=0", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL memerr_set got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid();
        int n;
        lat = 1; do_reset(); stall = 1'b1;
        n = 0;
        while (!(mem_req && mem_addr == 16'h0006) && n < 40) begin @(negedge clk); n++; end
        checks++; if (n >= 40 || pc !== 16'h0000) begin failures++; $display("FAIL mid_fill got=%0d/%h exp<40/0000", n, pc); end
        rst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instr !== 16'h0800)
            begin failures++; $display("FAIL mid_async got=%b/%b/%h exp=0/0/0800", instr_valid, mem_req, instr); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL mid_restart got=%b/%h exp=1/0000", mem_req, mem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {4'hA, i[11:0]};
        mem[0] = 16'h1111;
        mem[2] = 16'h2222;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_done();
        test_halt();
        test_wrap();
        test_mem_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
